fetch_queue_unit: RTL and testbench
===================================

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter XLEN, default 32: PC and address width.
REQ-002 Parameter DEPTH, default 4: fetch queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0: PC loaded on reset.
REQ-004 Parameter STEP, default 4: PC increment in bytes per fetched instruction.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 redirect_valid  input  1  branch or jump redirect request.
REQ-008 redirect_pc  input  XLEN  redirect target address.
REQ-009 imem_req_valid  output  1  fetch request to instruction memory.
REQ-010 imem_req_ready  input  1  memory accepts the request.
REQ-011 imem_req_addr  output  XLEN  fetch address, equal to the current PC.
REQ-012 imem_rsp_valid  input  1  instruction returned for the oldest accepted request.
REQ-013 imem_rsp_data  input  32  returned instruction word.
REQ-014 out_valid  output  1  queue head is valid for decode.
REQ-015 out_ready  input  1  decode consumes the head; this is the stall input, active low.
REQ-016 out_pc  output  XLEN  PC of the queue head.
REQ-017 out_instr  output  32  instruction word of the queue head.
REQ-018 occupancy  output  clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-019 A request SHALL be accepted when imem_req_valid and imem_req_ready are both high on a rising edge.
REQ-020 At most one request SHALL be outstanding; it remains outstanding from acceptance until its imem_rsp_valid.
REQ-021 imem_req_valid SHALL be high iff: not in reset, no request outstanding, occupancy below DEPTH, and redirect_valid low.
REQ-022 On acceptance, PC SHALL advance by STEP, modulo 2^XLEN (wraps to 0).
REQ-023 A response for a non-stale request SHALL push {requested address, imem_rsp_data} at the tail in the same edge.
REQ-024 Occupancy below DEPTH at issue SHALL be guaranteed, so a push never finds the queue full; overflow is unreachable.
REQ-025 out_valid SHALL equal (occupancy != 0); out_pc and out_instr SHALL be driven combinationally from the head entry.
REQ-026 A pop SHALL occur on an edge with out_valid and out_ready both high.
REQ-027 Push and pop on the same edge SHALL leave occupancy unchanged and preserve entry order.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 Redirect_valid SHALL have priority over all other events on its edge, with the following effects:
- PC is set to redirect_pc;
- occupancy is set to 0; any same-edge pop is void and any same-edge push is dropped;
- any outstanding request is marked stale.
REQ-030 A stale response SHALL be discarded without a push and SHALL clear the outstanding state.
REQ-031 A response arriving on the same edge as a redirect SHALL be discarded.
REQ-032 The first request after a redirect SHALL be issued the cycle after the redirect, once no request is outstanding.
REQ-033 Response latency SHALL be at least 1 cycle after acceptance; same-edge responses are illegal.
REQ-034 Fetch-to-out_valid latency SHALL be 1 cycle after imem_rsp_valid.

Reset
REQ-035 Asserting reset SHALL immediately apply all of the following:
- PC = RESET_PC;
- occupancy = 0, out_valid = 0, imem_req_valid = 0;
- pointers = 0;
- outstanding and stale flags cleared.
REQ-036 A response arriving during reset, or after reset for a request accepted before reset, SHALL be discarded.
REQ-037 The first request after reset SHALL present imem_req_addr = RESET_PC in the first cycle after reset deasserts.

Verification
REQ-038 The bench SHALL cover: reset release; memory ready always; 1-cycle responses; out_ready=1 -> out_pc sequence 0x0, 0x4, 0x8, ... with matching instructions and occupancy at most 1.
REQ-039 The bench SHALL cover: out_ready=0 for 10 cycles -> occupancy saturates at 4, imem_req_valid low, head out_pc=0x0 held; then out_ready=1 -> in-order drain 0x0..0xC.
REQ-040 The bench SHALL cover: redirect_pc=0x100 while 3 entries are queued and 1 request is outstanding -> next edge occupancy=0; stale response dropped; next accepted address 0x100; next out_pc 0x100.
REQ-041 The bench SHALL cover: XLEN=32, PC=0xFFFFFFFC accepted -> next imem_req_addr=0x00000000.
REQ-042 The bench SHALL cover: simultaneous push and pop at occupancy 2 -> occupancy stays 2, FIFO order intact.
REQ-043 The bench SHALL cover: reset asserted mid-fetch with 2 entries queued and 1 request outstanding -> outputs clear asynchronously; late response ignored; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Fetch queue unit: issues sequential instruction fetches (one outstanding at a
// time), buffers returned words with their PCs in a small FIFO for decode, and
// handles redirects by flushing the queue and discarding the in-flight reply.
module fetch_queue_unit #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               STEP     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] pc;
    logic            outstanding;
    logic            stale;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;

    logic accept;
    logic push;
    logic pop;

    // Issue only when idle, not full and not being redirected; the reset term
    // keeps the request low combinationally while reset is held.
    assign imem_req_valid = !reset && !outstanding && (count < (PW+1)'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && outstanding && !stale && !redirect_valid;
    assign out_valid      = (count != '0);
    assign pop            = out_valid && out_ready && !redirect_valid;
    assign out_pc         = q_pc[rd_ptr];
    assign out_instr      = q_instr[rd_ptr];
    assign occupancy      = count;

    // PC register: redirect wins, otherwise advance (wrapping) on each accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (accept) begin
            pc <= pc + XLEN'(STEP);
        end
    end

    // Outstanding/stale tracking for the single in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= 1'b0;
            stale       <= 1'b0;
        end else if (redirect_valid) begin
            // A reply on the redirect edge retires the request; otherwise the
            // in-flight request keeps waiting but its reply will be thrown away.
            if (imem_rsp_valid) begin
                outstanding <= 1'b0;
                stale       <= 1'b0;
            end else begin
                stale       <= outstanding;
            end
        end else if (accept) begin
            outstanding <= 1'b1;
            stale       <= 1'b0;
        end else if (imem_rsp_valid && outstanding) begin
            outstanding <= 1'b0;
            stale       <= 1'b0;
        end
    end

    // Address of the in-flight request, paired with its reply at push time.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr <= pc;
        end
    end

    // Queue storage: written at the tail on each non-stale reply.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= req_addr;
            q_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    // Pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Testbench for fetch_queue_unit: directed tables and sequences plus random
// traffic compared against a queue-based reference model.
module tb_fetch_queue_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          STEP     = 4;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  occupancy;

    fetch_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .STEP(STEP)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of {pc, instr} plus the fetch PC and the
    // in-flight request status.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_stale;
    logic [31:0] m_req;

    // Memory responder
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_data;
    int          lat_min;
    int          lat_max;

    int checks;
    int errors;

    typedef struct {
        logic        o_ready;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [2:0]  e_occ;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic bit exp_rv();
        return !reset && !m_out && (mq.size() < DEPTH) && !redirect_valid;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc    = RESET_PC;
        m_out   = 0;
        m_stale = 0;
    endtask

    // Drive the memory reply for this cycle and let outputs settle.
    task automatic prep();
        imem_rsp_valid = mem_busy && (mem_cnt == 0);
        imem_rsp_data  = imem_rsp_valid ? mem_data : $urandom;
        #1;
    endtask

    task automatic check_model();
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv()});
        chk("req_addr", imem_req_addr, m_pc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        chk("occupancy", {29'b0, occupancy}, mq.size());
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instr", out_instr, mq[0].instr);
        end
    endtask

    // Update model and memory from this cycle's inputs, then cross the edge.
    task automatic advance();
        bit   rv;
        bit   acc;
        bit   rsp;
        ent_t e;
        rv  = exp_rv();
        acc = rv && imem_req_ready;
        rsp = imem_rsp_valid;
        if (reset) begin
            model_reset();
        end else if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc;
            if (m_out) begin
                if (rsp) begin
                    m_out   = 0;
                    m_stale = 0;
                end else begin
                    m_stale = 1;
                end
            end
        end else begin
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (rsp && m_out) begin
                if (!m_stale) begin
                    e.pc    = m_req;
                    e.instr = imem_rsp_data;
                    mq.push_back(e);
                end
                m_out   = 0;
                m_stale = 0;
            end
            if (acc) begin
                m_out   = 1;
                m_stale = 0;
                m_req   = m_pc;
                m_pc    = m_pc + STEP;
            end
        end
        if (rsp) mem_busy = 0;
        else if (mem_busy && mem_cnt > 0) mem_cnt--;
        if (acc) begin
            mem_busy = 1;
            mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
            mem_data = $urandom;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle();
        prep();
        check_model();
        advance();
    endtask

    task automatic do_reset();
        reset          = 1;
        redirect_valid = 0;
        redirect_pc    = 0;
        imem_req_ready = 1;
        out_ready      = 1;
        imem_rsp_valid = 0;
        mem_busy       = 0;
        mem_cnt        = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        bit found;
        bit seen;
        checks = 0;
        errors = 0;
        imem_rsp_data = 0;
        lat_min = 1;
        lat_max = 1;

        tbl[0] = '{1'b1, 1'b1, 32'h0,  1'b0, 32'h0, 3'd0};
        tbl[1] = '{1'b1, 1'b0, 32'h4,  1'b0, 32'h0, 3'd0};
        tbl[2] = '{1'b1, 1'b1, 32'h4,  1'b1, 32'h0, 3'd1};
        tbl[3] = '{1'b1, 1'b0, 32'h8,  1'b0, 32'h0, 3'd0};
        tbl[4] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h4, 3'd1};
        tbl[5] = '{1'b1, 1'b0, 32'hC,  1'b0, 32'h0, 3'd0};
        tbl[6] = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h8, 3'd1};
        tbl[7] = '{1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 3'd0};

        // Reset release with 1-cycle memory and decode always ready
        do_reset();
        for (int i = 0; i < 8; i++) begin
            out_ready = tbl[i].o_ready;
            prep();
            chk($sformatf("tbl%0d_rv", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].e_rv});
            chk($sformatf("tbl%0d_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_ov", i), {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
            chk($sformatf("tbl%0d_occ", i), {29'b0, occupancy}, {29'b0, tbl[i].e_occ});
            if (tbl[i].e_ov) chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].e_pc);
            check_model();
            advance();
        end

        // Decode stalled for 10 cycles, then in-order drain
        do_reset();
        out_ready = 0;
        repeat (10) cycle();
        prep();
        chk("stall_occ", {29'b0, occupancy}, 32'd4);
        chk("stall_rv", {31'b0, imem_req_valid}, 32'd0);
        chk("stall_head", out_pc, 32'h0);
        check_model();
        advance();
        for (int i = 0; i < 4; i++) begin
            out_ready = 1;
            prep();
            check_model();
            chk($sformatf("drain%0d_pc", i), out_pc, i * 4);
            if (i == 3) chk("pushpop_occ", {29'b0, occupancy}, 32'd2);
            advance();
        end
        repeat (6) cycle();

        // Redirect with 3 queued and 1 outstanding
        do_reset();
        out_ready = 0;
        lat_min = 3;
        lat_max = 3;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            prep();
            check_model();
            if (mq.size() == 3 && m_out && mem_cnt > 0) begin
                found = 1;
                break;
            end
            advance();
        end
        chk("reach_redirect", {31'b0, found}, 32'd1);
        redirect_valid = 1;
        redirect_pc    = 32'h100;
        #1;
        check_model();
        advance();
        redirect_valid = 0;
        prep();
        chk("redir_occ", {29'b0, occupancy}, 32'd0);
        check_model();
        advance();
        out_ready = 1;
        seen  = 0;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            prep();
            check_model();
            if (imem_req_valid && imem_req_ready && !seen) begin
                chk("redir_addr", imem_req_addr, 32'h100);
                seen = 1;
            end
            if (out_valid) begin
                chk("redir_out_pc", out_pc, 32'h100);
                found = 1;
                advance();
                break;
            end
            advance();
        end
        chk("redir_seen_req", {31'b0, seen}, 32'd1);
        chk("redir_seen_out", {31'b0, found}, 32'd1);

        // PC wrap at the top of the address space
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 10; i++) begin
            prep();
            check_model();
            if (!m_out) break;
            advance();
        end
        redirect_valid = 1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        check_model();
        advance();
        redirect_valid = 0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            prep();
            check_model();
            if (imem_req_valid && imem_req_ready && imem_req_addr == 32'hFFFF_FFFC) begin
                advance();
                prep();
                chk("wrap_addr", imem_req_addr, 32'h0);
                found = 1;
                check_model();
                advance();
                break;
            end
            advance();
        end
        chk("wrap_seen", {31'b0, found}, 32'd1);
        repeat (4) cycle();

        // Reset mid-fetch with 2 queued and 1 outstanding
        do_reset();
        out_ready = 0;
        lat_min = 3;
        lat_max = 3;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            prep();
            check_model();
            if (mq.size() == 2 && m_out && mem_cnt > 0) begin
                found = 1;
                break;
            end
            advance();
        end
        chk("reach_reset", {31'b0, found}, 32'd1);
        #2;
        reset = 1;
        #1;
        chk("async_ov", {31'b0, out_valid}, 32'd0);
        chk("async_occ", {29'b0, occupancy}, 32'd0);
        chk("async_rv", {31'b0, imem_req_valid}, 32'd0);
        advance();
        cycle();
        reset = 0;
        imem_req_ready = 0;
        prep();
        chk("restart_rv", {31'b0, imem_req_valid}, 32'd1);
        chk("restart_addr", imem_req_addr, RESET_PC);
        check_model();
        advance();
        for (int i = 0; i < 10; i++) begin
            if (!mem_busy) break;
            cycle();
        end
        chk("late_rsp_done", {31'b0, mem_busy}, 32'd0);
        imem_req_ready = 1;
        out_ready = 1;
        repeat (8) cycle();

        // Random traffic against the reference model
        do_reset();
        lat_min = 1;
        lat_max = 3;
        for (int i = 0; i < 1000; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = $urandom & 32'hFFFF_FFFC;
            cycle();
        end
        redirect_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset          = 1;
        redirect_valid = 0;
        redirect_pc    = 0;
        imem_req_ready = 0;
        imem_rsp_valid = 0;
        out_ready      = 0;
    end

endmodule
